// File: rtl/mpdmac_pkg.sv
// Shared types and widths for the matrix DMA job queue.
package mpdmac_pkg;

    localparam int ADDR_W  = 32;
    localparam int WIDTH_W = 6;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  src;
        logic [ADDR_W-1:0]  dst;
        logic [WIDTH_W-1:0] width;
    } job_t;

endpackage

// File: rtl/mpdmac_jobq_fifo.sv
// Power-of-two job FIFO; the head entry is presented combinationally on o_data.
import mpdmac_pkg::*;

module mpdmac_jobq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  job_t                   i_data,
    output job_t                   o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    job_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mpdmac_jobq.sv
// Job queue and launch sequencer for the matrix DMA engine.
// Optional watchdog is built when MPDMAC_JOBQ_TIMEOUT_EN is defined.
import mpdmac_pkg::*;

module mpdmac_jobq #(
    parameter int DEPTH      = 4,
    parameter int TMO_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [ADDR_W-1:0]  job_src_i,
    input  logic [ADDR_W-1:0]  job_dst_i,
    input  logic [WIDTH_W-1:0] job_width_i,
    output logic [ADDR_W-1:0]  src_addr_o,
    output logic [ADDR_W-1:0]  dst_addr_o,
    output logic [WIDTH_W-1:0] mat_width_o,
    output logic               start_o,
    input  logic               done_i,
    output logic               busy_o,
    output logic               irq_o,
    input  logic               irq_clr_i,
    output logic [CNT_W-1:0]   done_cnt_o,
    output logic               tmo_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    job_t               w_job_in;
    job_t               w_head;

    state_t             r_state;
    logic               r_start;
    logic               r_irq;
    logic [CNT_W-1:0]   r_done_cnt;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [WIDTH_W-1:0] r_width;

    assign w_job_in    = '{src: job_src_i, dst: job_dst_i, width: job_width_i};
    assign job_ready_o = (w_count != CW'(DEPTH));
    assign w_push      = job_valid_i && !w_full;
    assign w_pop       = (r_state == IDLE) && !w_empty && done_i;
    assign busy_o      = (r_state != IDLE) || (w_count != '0);

    mpdmac_jobq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_job_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A completion in the same cycle as irq_clr_i must leave irq set, so the
    // set assignment comes after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_irq      <= 1'b0;
            r_done_cnt <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_width    <= '0;
        end else begin
            r_start <= 1'b0;
            if (irq_clr_i) r_irq <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_src   <= w_head.src;
                        r_dst   <= w_head.dst;
                        r_width <= w_head.width;
                        r_start <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!done_i) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        r_done_cnt <= r_done_cnt + 1'b1;
                        r_irq      <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_o     = r_start;
    assign irq_o       = r_irq;
    assign done_cnt_o  = r_done_cnt;
    assign src_addr_o  = r_src;
    assign dst_addr_o  = r_dst;
    assign mat_width_o = r_width;

`ifdef MPDMAC_JOBQ_TIMEOUT_EN
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_tmo;

    // Counts cycles spent waiting on the engine and saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else if (r_state == START) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == WAIT_BUSY || r_state == WAIT_DONE) &&
                     (r_tmo_cnt != CNT_W'(TMO_CYCLES))) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (r_tmo_cnt == CNT_W'(TMO_CYCLES - 1)) r_tmo <= 1'b1;
        end
    end

    assign tmo_o = r_tmo;
`else
    logic w_tmo_unused;

    assign w_tmo_unused = (TMO_CYCLES == 0);
    assign tmo_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mpdmac_jobq.sv
// Self-checking bench for mpdmac_jobq: vector table plus directed sequences.
// Timeout expectations follow MPDMAC_JOBQ_TIMEOUT_EN.
module tb_mpdmac_jobq;

    logic        clk;
    logic        rst;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [31:0] job_src_i;
    logic [31:0] job_dst_i;
    logic [5:0]  job_width_i;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [5:0]  mat_width_o;
    logic        start_o;
    logic        done_i;
    logic        busy_o;
    logic        irq_o;
    logic        irq_clr_i;
    logic [15:0] done_cnt_o;
    logic        tmo_o;

    typedef struct {
        logic        valid;
        logic [31:0] src;
        logic [31:0] dst;
        logic [5:0]  width;
        logic        done;
        logic        clr;
        logic        eStart;
        logic        eReady;
        logic        eBusy;
        logic        eIrq;
        logic [15:0] eCnt;
        logic [31:0] eSrc;
        logic [31:0] eDst;
        logic [5:0]  eWidth;
    } vec_t;

    localparam int NVEC = 13;

    vec_t        vecs [NVEC];
    int          testCount;
    int          failCount;
    int          cyc;
    logic [31:0] startSrc [8];
    int          startCyc [8];
    int          expTmo;

    mpdmac_jobq #(
        .DEPTH      (4),
        .TMO_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid_i (job_valid_i),
        .job_ready_o (job_ready_o),
        .job_src_i   (job_src_i),
        .job_dst_i   (job_dst_i),
        .job_width_i (job_width_i),
        .src_addr_o  (src_addr_o),
        .dst_addr_o  (dst_addr_o),
        .mat_width_o (mat_width_o),
        .start_o     (start_o),
        .done_i      (done_i),
        .busy_o      (busy_o),
        .irq_o       (irq_o),
        .irq_clr_i   (irq_clr_i),
        .done_cnt_o  (done_cnt_o),
        .tmo_o       (tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        job_valid_i = v.valid;
        job_src_i   = v.src;
        job_dst_i   = v.dst;
        job_width_i = v.width;
        done_i      = v.done;
        irq_clr_i   = v.clr;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        job_valid_i = 1'b0;
        job_src_i   = '0;
        job_dst_i   = '0;
        job_width_i = '0;
        done_i      = 1'b1;
        irq_clr_i   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pushJob(input logic [31:0] s, input logic [31:0] d, input logic [5:0] w);
        job_valid_i = 1'b1;
        job_src_i   = s;
        job_dst_i   = d;
        job_width_i = w;
        tick();
        job_valid_i = 1'b0;
    endtask

    // Engine model: drops done the cycle after a start pulse for 'busy' cycles.
    task automatic runEngine(input int n, input int busy);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < 200) begin
            tick();
            guard++;
            if (start_o) begin
                startSrc[seen] = src_addr_o;
                startCyc[seen] = cyc;
                seen++;
                tick();
                done_i = 1'b0;
                repeat (busy) tick();
                done_i = 1'b1;
            end
        end
        tick();
        checkOutput("engine_starts", 32'(seen), 32'(n));
    endtask

    initial begin
        int acc;
        int holdErr;
        testCount = 0;
        failCount = 0;
        cyc       = 0;
`ifdef MPDMAC_JOBQ_TIMEOUT_EN
        expTmo = 1;
`else
        expTmo = 0;
`endif

        //            valid src           dst           w      done clr   start rdy  busy irq  cnt    eSrc          eDst          eW
        vecs[0]  = '{1'b1, 32'h0000_1000, 32'h0000_2000, 6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0,         32'h0,         6'd0};
        vecs[1]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[2]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[3]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[4]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[5]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[6]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[7]  = '{1'b1, 32'hDEAD_BEEF, 32'h0123_4567, 6'd63, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 32'h0000_1000, 32'h0000_2000, 6'd8};
        vecs[8]  = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 32'hDEAD_BEEF, 32'h0123_4567, 6'd63};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0004, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 32'hDEAD_BEEF, 32'h0123_4567, 6'd63};
        vecs[10] = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 32'hDEAD_BEEF, 32'h0123_4567, 6'd63};
        vecs[11] = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 32'hDEAD_BEEF, 32'h0123_4567, 6'd63};
        vecs[12] = '{1'b0, 32'h0,         32'h0,         6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 32'hFFFF_FFFC, 32'h0000_0004, 6'd0};

        doReset();
        checkOutput("rst_ready", 32'(job_ready_o), 32'd1);
        checkOutput("rst_busy",  32'(busy_o),      32'd0);
        checkOutput("rst_start", 32'(start_o),     32'd0);
        checkOutput("rst_irq",   32'(irq_o),       32'd0);
        checkOutput("rst_cnt",   32'(done_cnt_o),  32'd0);
        checkOutput("rst_tmo",   32'(tmo_o),       32'd0);
        checkOutput("rst_src",   src_addr_o,       32'd0);
        checkOutput("rst_width", 32'(mat_width_o), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d_start", i), 32'(start_o),     32'(vecs[i].eStart));
            checkOutput($sformatf("v%0d_ready", i), 32'(job_ready_o), 32'(vecs[i].eReady));
            checkOutput($sformatf("v%0d_busy", i),  32'(busy_o),      32'(vecs[i].eBusy));
            checkOutput($sformatf("v%0d_irq", i),   32'(irq_o),       32'(vecs[i].eIrq));
            checkOutput($sformatf("v%0d_cnt", i),   32'(done_cnt_o),  32'(vecs[i].eCnt));
            checkOutput($sformatf("v%0d_src", i),   src_addr_o,       vecs[i].eSrc);
            checkOutput($sformatf("v%0d_dst", i),   dst_addr_o,       vecs[i].eDst);
            checkOutput($sformatf("v%0d_width", i), 32'(mat_width_o), 32'(vecs[i].eWidth));
        end

        // Single job with a 20-cycle engine run.
        doReset();
        pushJob(32'h1000, 32'h2000, 6'd8);
        job_src_i = 32'hFFFF_FFFF;
        job_dst_i = 32'hFFFF_FFFF;
        checkOutput("single_lat1_start", 32'(start_o), 32'd0);
        tick();
        checkOutput("single_lat2_start", 32'(start_o), 32'd1);
        checkOutput("single_src",   src_addr_o,       32'h1000);
        checkOutput("single_dst",   dst_addr_o,       32'h2000);
        checkOutput("single_width", 32'(mat_width_o), 32'd8);
        tick();
        done_i  = 1'b0;
        holdErr = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (start_o !== 1'b0 || src_addr_o !== 32'h1000 || dst_addr_o !== 32'h2000 ||
                mat_width_o !== 6'd8 || busy_o !== 1'b1) holdErr++;
        end
        checkOutput("single_hold_errors", 32'(holdErr), 32'd0);
        done_i = 1'b1;
        tick();
        checkOutput("single_irq",  32'(irq_o),      32'd1);
        checkOutput("single_cnt",  32'(done_cnt_o), 32'd1);
        checkOutput("single_busy", 32'(busy_o),     32'd0);

        // Fill the queue while the engine reports busy.
        doReset();
        done_i = 1'b0;
        acc    = 0;
        for (int i = 0; i < 5; i++) begin
            job_valid_i = 1'b1;
            job_src_i   = 32'h100 * (i + 1);
            job_dst_i   = 32'h9000 + i;
            job_width_i = 6'(i + 1);
            if (job_ready_o) acc++;
            tick();
        end
        checkOutput("fill_accepted",  32'(acc),         32'd4);
        checkOutput("fill_ready_low", 32'(job_ready_o), 32'd0);
        repeat (3) tick();
        checkOutput("fill_held_ready", 32'(job_ready_o), 32'd0);
        checkOutput("fill_no_start",   32'(start_o),     32'd0);
        done_i = 1'b1;
        tick();
        checkOutput("fill_first_start", 32'(start_o),     32'd1);
        checkOutput("fill_first_src",   src_addr_o,       32'h100);
        checkOutput("fill_first_width", 32'(mat_width_o), 32'd1);
        checkOutput("fill_ready_after_pop", 32'(job_ready_o), 32'd1);
        tick();
        job_valid_i = 1'b0;
        done_i      = 1'b0;
        checkOutput("fill_fifth_taken", 32'(job_ready_o), 32'd0);
        tick();
        done_i = 1'b1;
        runEngine(4, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fill_order%0d", i), startSrc[i], 32'h100 * (i + 2));
        end
        checkOutput("fill_cnt",  32'(done_cnt_o), 32'd5);
        checkOutput("fill_busy", 32'(busy_o),     32'd0);

        // Back-to-back jobs with a one-cycle engine.
        doReset();
        done_i = 1'b0;
        pushJob(32'hA0, 32'h1A0, 6'd1);
        pushJob(32'hB0, 32'h1B0, 6'd2);
        pushJob(32'hC0, 32'h1C0, 6'd3);
        done_i = 1'b1;
        runEngine(3, 1);
        checkOutput("b2b_src0", startSrc[0], 32'hA0);
        checkOutput("b2b_src1", startSrc[1], 32'hB0);
        checkOutput("b2b_src2", startSrc[2], 32'hC0);
        checkOutput("b2b_gap01", 32'(startCyc[1] - startCyc[0]), 32'd4);
        checkOutput("b2b_gap12", 32'(startCyc[2] - startCyc[1]), 32'd4);
        checkOutput("b2b_cnt",   32'(done_cnt_o), 32'd3);

        // Interrupt clear colliding with completion.
        doReset();
        pushJob(32'h55, 32'h66, 6'd4);
        tick();
        tick();
        done_i = 1'b0;
        tick();
        done_i    = 1'b1;
        irq_clr_i = 1'b1;
        tick();
        checkOutput("irq_set_wins", 32'(irq_o),      32'd1);
        checkOutput("irq_cnt",      32'(done_cnt_o), 32'd1);
        tick();
        checkOutput("irq_cleared", 32'(irq_o), 32'd0);
        irq_clr_i = 1'b0;

        // Reset while waiting on the engine with two jobs queued.
        doReset();
        done_i = 1'b0;
        pushJob(32'h11, 32'h21, 6'd1);
        pushJob(32'h12, 32'h22, 6'd2);
        pushJob(32'h13, 32'h23, 6'd3);
        done_i = 1'b1;
        tick();
        checkOutput("midrst_started", 32'(start_o), 32'd1);
        tick();
        done_i = 1'b0;
        tick();
        checkOutput("midrst_busy_before", 32'(busy_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_busy",  32'(busy_o),      32'd0);
        checkOutput("midrst_ready", 32'(job_ready_o), 32'd1);
        checkOutput("midrst_src",   src_addr_o,       32'd0);
        checkOutput("midrst_cnt",   32'(done_cnt_o),  32'd0);
        done_i  = 1'b1;
        holdErr = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (start_o !== 1'b0 || busy_o !== 1'b0) holdErr++;
        end
        checkOutput("midrst_no_start", 32'(holdErr), 32'd0);

        // Watchdog with a limit of 100 wait cycles.
        doReset();
        pushJob(32'h77, 32'h88, 6'd5);
        tick();
        tick();
        done_i = 1'b0;
        repeat (99) tick();
        checkOutput("tmo_before_limit", 32'(tmo_o), 32'd0);
        tick();
        checkOutput("tmo_at_limit", 32'(tmo_o), 32'(expTmo));
        done_i = 1'b1;
        tick();
        checkOutput("tmo_sticky",    32'(tmo_o),  32'(expTmo));
        checkOutput("tmo_fsm_idle",  32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mpdmac_jobq.md
MPDMAC_JOBQ -- requirements
Module: mpdmac_jobq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-002 Parameter DEPTH, default 4 (power of two, 2..16): number of job-queue entries.
REQ-003 Parameter TMO_CYCLES, default 65535: watchdog limit in cycles, used only when MPDMAC_JOBQ_TIMEOUT_EN is defined.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 job_valid_i  in  1  a job is offered.
REQ-007 job_ready_o  out  1  the queue can accept a job.
REQ-008 job_src_i  in  32  source address of the job.
REQ-009 job_dst_i  in  32  destination address of the job.
REQ-010 job_width_i  in  6  matrix width of the job.
REQ-011 src_addr_o  out  32  source address driven to the engine.
REQ-012 dst_addr_o  out  32  destination address driven to the engine.
REQ-013 mat_width_o  out  6  matrix width driven to the engine.
REQ-014 start_o  out  1  one-cycle start pulse to the engine.
REQ-015 done_i  in  1  engine done level (high = engine idle).
REQ-016 busy_o  out  1  a job is in flight or the queue is non-empty.
REQ-017 irq_o  out  1  sticky completion interrupt.
REQ-018 irq_clr_i  in  1  clears irq_o.
REQ-019 done_cnt_o  out  16  count of completed jobs.
REQ-020 tmo_o  out  1  sticky watchdog flag.

Function
REQ-021 Queue: FIFO of DEPTH entries, each holding {src, dst, width}.
- job_ready_o = (count != DEPTH), which depends only on the registered count.
- A push occurs when job_valid_i && job_ready_o.
REQ-022 Simultaneous push and pop:
- If not full, both occur and count is unchanged.
- If full, only the pop occurs (ready was already low).
REQ-023 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE -> START when the queue is non-empty and done_i=1.
- On that transition: pop the head and register it into src_addr_o, dst_addr_o and mat_width_o.
REQ-025 START: start_o=1 for exactly this one cycle; the next state is WAIT_BUSY.
- The engine outputs stay stable from START until the next pop.
REQ-026 WAIT_BUSY -> WAIT_DONE when done_i=0.
REQ-027 WAIT_DONE -> IDLE when done_i=1.
- On that transition: done_cnt_o increments, wrapping 0xFFFF -> 0x0000, and irq_o sets.
REQ-028 Back-to-back jobs: the minimum spacing is one IDLE cycle, so start pulses are at least 4 cycles apart.
REQ-029 irq_o clears on irq_clr_i; if completion and irq_clr_i happen in the same cycle, set wins.
REQ-030 busy_o = (state != IDLE) || (count != 0), as a combinational decode of registered state.
REQ-031 Job latency: a push into an empty queue while idle and done_i=1 gives start_o=1 exactly 2 cycles after the push cycle.
REQ-032 Pushes in any FSM state are accepted subject to job_ready_o only.

Reset
REQ-033 On reset:
- Queue pointers and count = 0; state = IDLE.
- start_o=0, irq_o=0, tmo_o=0, done_cnt_o=0.
- src_addr_o=0, dst_addr_o=0, mat_width_o=0.
- job_ready_o=1, busy_o=0.
REQ-034 Reset mid-job discards all queued jobs and the in-flight tracking; the FSM does not wait for done_i.

Configuration
REQ-035 With MPDMAC_JOBQ_TIMEOUT_EN defined, the watchdog is built:
- A 16-bit counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
- On reaching TMO_CYCLES it sets tmo_o (sticky, cleared only by reset) and saturates.
- FSM behaviour is unchanged.
REQ-036 Without MPDMAC_JOBQ_TIMEOUT_EN, the counter is not built and tmo_o is tied to 0.

Structure
REQ-037 A shared package mpdmac_pkg SHALL hold:
- the state enum typedef;
- the job struct typedef {src 32, dst 32, width 6};
- the widths ADDR_W=32, WIDTH_W=6, CNT_W=16.
REQ-038 The FIFO SHALL be a sub-module mpdmac_jobq_fifo (parameter DEPTH, job struct payload, push/pop/full/empty/count); the FSM and counters live in the top module.

Verification
REQ-039 Single job: push {0x1000, 0x2000, 8} with done_i=1 -> start_o high 2 cycles later; the engine outputs hold those values; the engine model drops done_i for 20 cycles and raises it -> irq_o=1, done_cnt_o=1, busy_o=0.
REQ-040 Fill: push 5 jobs while the engine is held busy (done_i=0), DEPTH=4 -> 4 accepted, job_ready_o=0, the 5th is held until the first pop.
REQ-041 Back-to-back: 3 jobs, each with 1-cycle engine busy -> 3 start pulses in push order, each 4 cycles apart; done_cnt_o=3.
REQ-042 irq_clr_i asserted in the same cycle as completion -> irq_o stays 1; asserted the next cycle -> irq_o=0.
REQ-043 Reset asserted in WAIT_DONE with 2 jobs queued -> next cycle state=IDLE, count=0, busy_o=0, no further start_o.
REQ-044 Timeout: with MPDMAC_JOBQ_TIMEOUT_EN and TMO_CYCLES=100, done_i held at 0 -> tmo_o=1 after 100 cycles in wait; without the macro, tmo_o stays 0.
